// File: rtl/sha_pass_sequencer_if.sv
// Handshake and control bundle between the job front-end, the pass sequencer and the hash core.
// The sequencer sits on the slave side; the front-end/core side uses master.

interface sha_pass_sequencer_if;
    logic       start;
    logic       abort;
    logic       hash_ack;
    logic [1:0] block_sel;
    logic       load_wv;
    logic       round_en;
    logic [5:0] round_idx;
    logic [1:0] pass;
    logic       busy;
    logic       hash_valid;

    modport master (
        output start,
        output abort,
        output hash_ack,
        input  block_sel,
        input  load_wv,
        input  round_en,
        input  round_idx,
        input  pass,
        input  busy,
        input  hash_valid
    );

    modport slave (
        input  start,
        input  abort,
        input  hash_ack,
        output block_sel,
        output load_wv,
        output round_en,
        output round_idx,
        output pass,
        output busy,
        output hash_valid
    );
endinterface

// File: rtl/sha_pass_sequencer.sv
// Control FSM for one double-SHA-256 job: three LOAD/RND/ACC passes, then DONE until acked.
// Drives the shared H-register Block code, the round index and the message-select pass number.

module sha_pass_sequencer #(
    parameter int unsigned ROUNDS     = 64,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sha_pass_sequencer_if.slave        seq_if
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StRnd  = 3'd2;
    localparam logic [2:0] StAcc  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam int unsigned AccW      = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [5:0]  LastRound = 6'(ROUNDS - 1);
    localparam logic [AccW-1:0] LastAcc = AccW'(ACC_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic [1:0]      pass_q, pass_d;
    logic [5:0]      round_q, round_d;
    logic [AccW-1:0] acc_q, acc_d;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        round_d = round_q;
        acc_d   = acc_q;

        case (state_q)
            StIdle: begin
                if (seq_if.start) begin
                    state_d = StLoad;
                    pass_d  = 2'd1;
                end
            end
            StLoad: begin
                state_d = StRnd;
                round_d = 6'd0;
            end
            StRnd: begin
                // Stop at the last round rather than wrapping the index.
                if (round_q == LastRound) begin
                    state_d = StAcc;
                    acc_d   = '0;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            StAcc: begin
                if (acc_q == LastAcc) begin
                    if (pass_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                        pass_d  = pass_q + 2'd1;
                    end
                end else begin
                    acc_d = acc_q + AccW'(1);
                end
            end
            StDone: begin
                if (seq_if.hash_ack) begin
                    state_d = StIdle;
                    pass_d  = 2'd0;
                    round_d = 6'd0;
                end
            end
            default: begin
                state_d = StIdle;
                pass_d  = 2'd0;
                round_d = 6'd0;
                acc_d   = '0;
            end
        endcase

        // Abort outranks hash_ack and every in-job transition.
        if (seq_if.abort && (state_q != StIdle)) begin
            state_d = StIdle;
            pass_d  = 2'd0;
            round_d = 6'd0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pass_q  <= 2'd0;
            round_q <= 6'd0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            round_q <= round_d;
            acc_q   <= acc_d;
        end
    end

    // Block code only moves on the first ACC cycle of a pass and holds through the next LOAD/RND,
    // so each H word sees exactly one code change per accumulate.
    always_comb begin
        case (state_q)
            StLoad, StRnd: seq_if.block_sel = pass_q - 2'd1;
            StAcc:         seq_if.block_sel = pass_q;
            StDone:        seq_if.block_sel = 2'd3;
            default:       seq_if.block_sel = 2'd0;
        endcase
    end

    assign seq_if.load_wv    = (state_q == StLoad);
    assign seq_if.round_en   = (state_q == StRnd);
    assign seq_if.round_idx  = round_q;
    assign seq_if.pass       = pass_q;
    assign seq_if.busy       = (state_q == StLoad) || (state_q == StRnd) || (state_q == StAcc);
    assign seq_if.hash_valid = (state_q == StDone);

    round_idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        round_q <= LastRound);

endmodule

// File: tb/tb_sha_pass_sequencer.sv
// Directed bench for sha_pass_sequencer: default instance (64 rounds, 2 acc cycles)
// plus a small instance (4 rounds, 1 acc cycle) for the parameter check.

module tb_sha_pass_sequencer;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    sha_pass_sequencer_if a_if ();
    sha_pass_sequencer_if b_if ();

    sha_pass_sequencer #(.ROUNDS(64), .ACC_CYCLES(2)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (a_if)
    );

    sha_pass_sequencer #(.ROUNDS(4), .ACC_CYCLES(1)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // {hash_valid, busy, pass, block_sel, round_en, load_wv, round_idx (only while round_en)}
    function automatic logic [13:0] obs_a();
        return {a_if.hash_valid, a_if.busy, a_if.pass, a_if.block_sel, a_if.round_en,
                a_if.load_wv, (a_if.round_en ? a_if.round_idx : 6'd0)};
    endfunction

    function automatic logic [13:0] obs_b();
        return {b_if.hash_valid, b_if.busy, b_if.pass, b_if.block_sel, b_if.round_en,
                b_if.load_wv, (b_if.round_en ? b_if.round_idx : 6'd0)};
    endfunction

    // Expected outputs in cycle c after the start edge (c=1 is the first LOAD).
    function automatic logic [13:0] model(input int c, input int rounds, input int accc);
        int         plen;
        int         p;
        int         o;
        logic [1:0] bs;
        logic       re;
        logic       lw;
        logic [5:0] idx;
        plen = 1 + rounds + accc;
        if (c >= 1 + 3 * plen) return {1'b1, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 6'd0};
        p   = (c - 1) / plen + 1;
        o   = (c - 1) % plen;
        re  = 1'b0;
        lw  = 1'b0;
        idx = 6'd0;
        if (o == 0) begin
            lw = 1'b1;
            bs = 2'(p - 1);
        end else if (o <= rounds) begin
            re  = 1'b1;
            idx = 6'(o - 1);
            bs  = 2'(p - 1);
        end else begin
            bs = 2'(p);
        end
        return {1'b0, 1'b1, 2'(p), bs, re, lw, idx};
    endfunction

    // Check cycles c0..c1 of a default-instance job; ends sitting in cycle c1.
    task automatic run_a(input string tag, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            if (c != c0) tick();
            check_eq($sformatf("%s c=%0d", tag, c), 32'(obs_a()), 32'(model(c, 64, 2)));
        end
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        a_if.start  = 1'b0;
        a_if.abort  = 1'b0;
        a_if.hash_ack = 1'b0;
        b_if.start  = 1'b0;
        b_if.abort  = 1'b0;
        b_if.hash_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("reset_vec", 32'(obs_a()), 32'd0);
        check_eq("reset_idx", 32'(a_if.round_idx), 32'd0);
        check_eq("reset_vec_b", 32'(obs_b()), 32'd0);

        // Full job from a single start pulse.
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        run_a("job1", 1, 202);
        check_eq("job1_valid", 32'(a_if.hash_valid), 32'd1);

        // Withhold the ack: DONE must hold block_sel=3.
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq($sformatf("hold %0d", i), 32'(obs_a()), 32'(model(999, 64, 2)));
        end
        a_if.hash_ack = 1'b1;
        tick();
        a_if.hash_ack = 1'b0;
        check_eq("ack_idle", 32'(obs_a()), 32'd0);

        // Reset for two cycles in the middle of pass 2.
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        run_a("job2", 1, 80);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("midrst_vec", 32'(obs_a()), 32'd0);
        check_eq("midrst_idx", 32'(a_if.round_idx), 32'd0);
        tick();
        check_eq("midrst_stay", 32'(obs_a()), 32'd0);

        // Abort in pass 3 at round 10, then a fresh job.
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        run_a("job3", 1, 146);
        check_eq("abort_at_idx", 32'(a_if.round_idx), 32'd10);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        check_eq("abort_vec", 32'(obs_a()), 32'd0);
        check_eq("abort_bsel", 32'(a_if.block_sel), 32'd0);
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        run_a("job4", 1, 202);
        a_if.hash_ack = 1'b1;
        tick();
        a_if.hash_ack = 1'b0;
        check_eq("job4_idle", 32'(obs_a()), 32'd0);

        // Start held high for the whole job, then ack+start together in DONE.
        a_if.start = 1'b1;
        tick();
        run_a("job5", 1, 205);
        a_if.hash_ack = 1'b1;
        tick();
        a_if.start    = 1'b0;
        a_if.hash_ack = 1'b0;
        check_eq("ackstart_idle", 32'(obs_a()), 32'd0);
        tick();
        check_eq("ackstart_noq", 32'(obs_a()), 32'd0);

        // Small instance: pass length 6, hash_valid at k+19.
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            if (c != 1) tick();
            check_eq($sformatf("small c=%0d", c), 32'(obs_b()), 32'(model(c, 4, 1)));
        end
        check_eq("small_valid", 32'(b_if.hash_valid), 32'd1);
        // Abort and ack together in DONE: abort wins, result is still IDLE.
        b_if.abort    = 1'b1;
        b_if.hash_ack = 1'b1;
        tick();
        b_if.abort    = 1'b0;
        b_if.hash_ack = 1'b0;
        check_eq("small_abort_idle", 32'(obs_b()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
